tetris_field_engine: RTL and testbench

- Parametrised playfield engine for the falling-block game; successor to the fixed 8x8 on-matrix game core.
- Owns the occupancy bitmap. Answers piece-collision queries and merges locked pieces. Clears any number of full rows and compacts the field.
- Tracks line total, level and game over.
- Sits between the piece-control FSM (input/drop timing) and the LED matrix, 7-seg and beeper drivers.

---
 rtl/tetris_pkg.sv | 29 ++
 rtl/tetris_field_engine_if.sv | 33 +++
 rtl/tetris_mask_place.sv | 44 ++++
 rtl/tetris_field_engine.sv | 239 +++++++++++++++++++++++
 tb/tb_tetris_field_engine.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// Shared types and constants for the playfield engine: FSM states, the 4x4 piece-mask
// bit indexing helper and the standard piece/rotation mask table.
package tetris_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMerge,
    StScan,
    StShift,
    StFinish,
    StOver
  } state_e;

  // Bit r*4+c of a piece mask is the cell at box column c, box row r (row 0 = bottom).
  function automatic logic [3:0] mask_idx(input int unsigned r, input int unsigned c);
    return 4'(r * 4 + c);
  endfunction

  localparam logic [15:0] PIECE_ROM [7][4] = '{
    '{16'h000F, 16'h1111, 16'h000F, 16'h1111},  // I
    '{16'h0033, 16'h0033, 16'h0033, 16'h0033},  // O
    '{16'h0027, 16'h0131, 16'h0072, 16'h0232},  // T
    '{16'h0063, 16'h0132, 16'h0063, 16'h0132},  // S
    '{16'h0036, 16'h0231, 16'h0036, 16'h0231},  // Z
    '{16'h0017, 16'h0311, 16'h0074, 16'h0223},  // J
    '{16'h0047, 16'h0113, 16'h0071, 16'h0322}   // L
  };

endpackage

// File: rtl/tetris_field_engine_if.sv
// Query and lock channels between the piece-control FSM (master) and the field engine (slave).
interface tetris_field_engine_if #(
    parameter int unsigned COLS       = 8,
    parameter int unsigned ROWS       = 8,
    parameter int unsigned SPAWN_ROWS = 2
);
  localparam int unsigned XW = $clog2(COLS) + 2;
  localparam int unsigned YW = $clog2(ROWS + SPAWN_ROWS) + 2;

  logic                 q_valid;
  logic signed [XW-1:0] q_x;
  logic signed [YW-1:0] q_y;
  logic [15:0]          q_mask;
  logic                 q_hit;
  logic                 q_done;

  logic                 lock_valid;
  logic                 lock_ready;
  logic signed [XW-1:0] lock_x;
  logic signed [YW-1:0] lock_y;
  logic [15:0]          lock_mask;

  modport master (
    output q_valid, q_x, q_y, q_mask, lock_valid, lock_x, lock_y, lock_mask,
    input  q_hit, q_done, lock_ready
  );

  modport slave (
    input  q_valid, q_x, q_y, q_mask, lock_valid, lock_x, lock_y, lock_mask,
    output q_hit, q_done, lock_ready
  );

endinterface

// File: rtl/tetris_mask_place.sv
// Expands a 4x4 piece mask at signed (x, y) into a per-row field overlay and flags any set
// cell lying left, right or below the field. Cells above the top row are simply dropped.
module tetris_mask_place
  import tetris_pkg::*;
#(
    parameter int unsigned COLS  = 8,
    parameter int unsigned NROWS = 10,
    parameter int unsigned XW    = 5,
    parameter int unsigned YW    = 6
) (
    input  logic signed [XW-1:0]         x,
    input  logic signed [YW-1:0]         y,
    input  logic [15:0]                  mask,
    output logic [NROWS-1:0][COLS-1:0]   overlay,
    output logic                         oob
);

  int dr, dc;

  always_comb begin
    overlay = '0;
    oob     = 1'b0;
    dr      = 0;
    dc      = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (mask[mask_idx(r, c)] &&
            (int'(x) + c < 0 || int'(x) + c >= int'(COLS) || int'(y) + r < 0)) begin
          oob = 1'b1;
        end
      end
    end
    for (int rr = 0; rr < int'(NROWS); rr++) begin
      for (int cc = 0; cc < int'(COLS); cc++) begin
        dr = rr - int'(y);
        dc = cc - int'(x);
        if (dr >= 0 && dr < 4 && dc >= 0 && dc < 4) begin
          overlay[rr][cc] = mask[mask_idx(dr, dc)];
        end
      end
    end
  end

endmodule

// File: rtl/tetris_field_engine.sv
// Playfield engine: owns the occupancy bitmap, answers collision queries, merges locked
// pieces, clears/compacts full rows and tracks line total, level and game over.
module tetris_field_engine
  import tetris_pkg::*;
#(
    parameter int unsigned COLS            = 8,
    parameter int unsigned ROWS            = 8,
    parameter int unsigned SPAWN_ROWS      = 2,
    parameter int unsigned LINES_PER_LEVEL = 3,
    parameter int unsigned MAX_LEVEL       = 9,
    localparam int unsigned XW             = $clog2(COLS) + 2,
    localparam int unsigned YW             = $clog2(ROWS + SPAWN_ROWS) + 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    tetris_field_engine_if.slave bus,
    output logic                 busy,
    output logic                 clear_pulse,
    output logic [2:0]           clear_count,
    output logic [3:0]           level,
    output logic                 level_up,
    output logic [15:0]          line_total,
    output logic                 game_over,
    input  logic [YW-1:0]        rd_row,
    output logic [COLS-1:0]      rd_data
);

  localparam int unsigned TOT = ROWS + SPAWN_ROWS;
  localparam int unsigned RW  = $clog2(ROWS + 1);

  typedef logic [TOT-1:0][COLS-1:0] field_t;

  state_e               state_q, state_d;
  field_t               field_q, field_d, q_ov, lk_ov;
  logic [RW-1:0]        row_q, row_d;
  logic [2:0]           cnt_q, cnt_d, ccount_q, ccount_d;
  logic [7:0]           step_q, step_d;
  logic [3:0]           level_q, level_d;
  logic [15:0]          line_q, line_d;
  logic                 cpulse_q, cpulse_d, lvlup_q, lvlup_d, over_q, over_d;
  logic                 hit_q, hit_d, done_q, done_d;
  logic [COLS-1:0]      rd_q, rd_d;
  logic signed [XW-1:0] lk_x_q, lk_x_d;
  logic signed [YW-1:0] lk_y_q, lk_y_d;
  logic [15:0]          lk_mask_q, lk_mask_d;
  logic                 q_oob, lk_oob, unused_lk_oob;
  logic                 row_full, next_full, spawn_occ;
  logic [16:0]          sum;
  int unsigned          stp_i, lvl_i;

  tetris_mask_place #(.COLS(COLS), .NROWS(TOT), .XW(XW), .YW(YW)) u_q_place (
    .x       (bus.q_x),
    .y       (bus.q_y),
    .mask    (bus.q_mask),
    .overlay (q_ov),
    .oob     (q_oob)
  );

  // Lock path drops out-of-range cells, so its flag is intentionally ignored.
  tetris_mask_place #(.COLS(COLS), .NROWS(TOT), .XW(XW), .YW(YW)) u_lk_place (
    .x       (lk_x_q),
    .y       (lk_y_q),
    .mask    (lk_mask_q),
    .overlay (lk_ov),
    .oob     (lk_oob)
  );
  assign unused_lk_oob = lk_oob;

  assign busy           = (state_q == StMerge) || (state_q == StScan) ||
                          (state_q == StShift) || (state_q == StFinish);
  assign bus.lock_ready = (state_q == StIdle) && !over_q;

  always_comb begin
    state_d   = state_q;
    field_d   = field_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    level_d   = level_q;
    line_d    = line_q;
    ccount_d  = ccount_q;
    cpulse_d  = 1'b0;
    lvlup_d   = 1'b0;
    over_d    = over_q;
    lk_x_d    = lk_x_q;
    lk_y_d    = lk_y_q;
    lk_mask_d = lk_mask_q;
    row_full  = 1'b0;
    next_full = 1'b0;
    spawn_occ = 1'b0;
    sum       = '0;
    stp_i     = 0;
    lvl_i     = 0;
    for (int i = 0; i < int'(ROWS); i++) begin
      if (32'(row_q) == i) row_full = &field_q[i];
    end
    for (int i = 0; i < int'(TOT) - 1; i++) begin
      if (32'(row_q) == i) next_full = &field_q[i+1];
    end
    for (int i = ROWS; i < int'(TOT); i++) spawn_occ |= |field_q[i];

    unique case (state_q)
      StIdle: begin
        if (bus.lock_valid && bus.lock_ready) begin
          lk_x_d    = bus.lock_x;
          lk_y_d    = bus.lock_y;
          lk_mask_d = bus.lock_mask;
          state_d   = StMerge;
        end
      end
      StMerge: begin
        field_d = field_q | lk_ov;
        row_d   = '0;
        cnt_d   = '0;
        state_d = StScan;
      end
      StScan: begin
        if (row_full) state_d = StShift;
        else if (32'(row_q) + 1 >= ROWS) state_d = StFinish;
        else row_d = row_q + RW'(1);
      end
      StShift: begin
        // The row dropping into r is tested here, so each cycle either clears or advances.
        for (int i = 0; i < int'(TOT) - 1; i++) begin
          if (i >= 32'(row_q)) field_d[i] = field_q[i+1];
        end
        field_d[TOT-1] = '0;
        cnt_d          = cnt_q + 3'd1;
        if (next_full) state_d = StShift;
        else if (32'(row_q) + 1 >= ROWS) state_d = StFinish;
        else begin
          row_d   = row_q + RW'(1);
          state_d = StScan;
        end
      end
      StFinish: begin
        ccount_d = cnt_q;
        cpulse_d = (cnt_q != 3'd0);
        sum      = {1'b0, line_q} + {14'b0, cnt_q};
        line_d   = sum[16] ? 16'hFFFF : sum[15:0];
        stp_i    = 32'(step_q) + 32'(cnt_q);
        lvl_i    = 32'(level_q);
        for (int k = 0; k < 5; k++) begin
          if (stp_i >= LINES_PER_LEVEL) begin
            stp_i = stp_i - LINES_PER_LEVEL;
            if (lvl_i < MAX_LEVEL) lvl_i = lvl_i + 1;
          end
        end
        step_d  = 8'(stp_i);
        level_d = 4'(lvl_i);
        lvlup_d = (lvl_i != 32'(level_q));
        if (spawn_occ) begin
          over_d  = 1'b1;
          state_d = StOver;
        end else begin
          state_d = StIdle;
        end
      end
      StOver:  state_d = StOver;
      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d  = StIdle;
      field_d  = '0;
      row_d    = '0;
      cnt_d    = '0;
      step_d   = '0;
      level_d  = '0;
      line_d   = '0;
      ccount_d = '0;
      cpulse_d = 1'b0;
      lvlup_d  = 1'b0;
      over_d   = 1'b0;
    end
  end

  always_comb begin
    done_d = bus.q_valid;
    hit_d  = hit_q;
    if (bus.q_valid) hit_d = busy || q_oob || (|(q_ov & field_q));
    rd_d = '0;
    for (int i = 0; i < int'(TOT); i++) begin
      if (32'(rd_row) == i) rd_d = field_q[i];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      field_q   <= '0;
      row_q     <= '0;
      cnt_q     <= '0;
      step_q    <= '0;
      level_q   <= '0;
      line_q    <= '0;
      ccount_q  <= '0;
      cpulse_q  <= 1'b0;
      lvlup_q   <= 1'b0;
      over_q    <= 1'b0;
      hit_q     <= 1'b0;
      done_q    <= 1'b0;
      rd_q      <= '0;
      lk_x_q    <= '0;
      lk_y_q    <= '0;
      lk_mask_q <= '0;
    end else begin
      state_q   <= state_d;
      field_q   <= field_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      level_q   <= level_d;
      line_q    <= line_d;
      ccount_q  <= ccount_d;
      cpulse_q  <= cpulse_d;
      lvlup_q   <= lvlup_d;
      over_q    <= over_d;
      hit_q     <= hit_d;
      done_q    <= done_d;
      rd_q      <= rd_d;
      lk_x_q    <= lk_x_d;
      lk_y_q    <= lk_y_d;
      lk_mask_q <= lk_mask_d;
    end
  end

  assign bus.q_hit   = hit_q;
  assign bus.q_done  = done_q;
  assign clear_pulse = cpulse_q;
  assign clear_count = ccount_q;
  assign level       = level_q;
  assign level_up    = lvlup_q;
  assign line_total  = line_q;
  assign game_over   = over_q;
  assign rd_data     = rd_q;

endmodule

// File: tb/tb_tetris_field_engine.sv
// Bench for tetris_field_engine: query results go through a scoreboard queue, lock
// sequences are checked for latency, clear/level strobes and resulting field contents.
module tb_tetris_field_engine;
  import tetris_pkg::*;

  localparam int unsigned COLS = 8;
  localparam int unsigned ROWS = 8;
  localparam int unsigned SPAWN = 2;
  localparam int unsigned TOT = ROWS + SPAWN;
  localparam int unsigned XW = $clog2(COLS) + 2;
  localparam int unsigned YW = $clog2(TOT) + 2;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            start = 1'b0;
  logic            busy, clear_pulse, level_up, game_over;
  logic [2:0]      clear_count;
  logic [3:0]      level;
  logic [15:0]     line_total;
  logic [YW-1:0]   rd_row = '0;
  logic [COLS-1:0] rd_data;

  always #5 CLK = ~CLK;

  tetris_field_engine_if #(.COLS(COLS), .ROWS(ROWS), .SPAWN_ROWS(SPAWN)) bus ();

  tetris_field_engine #(
    .COLS(COLS), .ROWS(ROWS), .SPAWN_ROWS(SPAWN), .LINES_PER_LEVEL(3), .MAX_LEVEL(9)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .clear_pulse (clear_pulse),
    .clear_count (clear_count),
    .level       (level),
    .level_up    (level_up),
    .line_total  (line_total),
    .game_over   (game_over),
    .rd_row      (rd_row),
    .rd_data     (rd_data)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  string tag_q[$];
  logic  exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pop one expected hit per q_done strobe.
  always @(negedge CLK) begin
    if (RST_N && bus.q_done) begin
      check_eq("q_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_eq(tag_q.pop_front(), 32'(bus.q_hit), 32'(exp_q.pop_front()));
    end
  end

  task automatic query(input string tag, input int x, input int y, input logic [15:0] m,
                       input logic exp);
    @(posedge CLK); #1;
    bus.q_valid = 1'b1;
    bus.q_x     = XW'(x);
    bus.q_y     = YW'(y);
    bus.q_mask  = m;
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    @(posedge CLK); #1;
    bus.q_valid = 1'b0;
    @(negedge CLK);
    check_eq({tag, "_done"}, 32'(bus.q_done), 32'd1);
  endtask

  task automatic lock_piece(input int x, input int y, input logic [15:0] m,
                            output int bc, output int pulses, output int lvlups);
    int idle;
    idle = 0; bc = 0; pulses = 0; lvlups = 0;
    @(posedge CLK); #1;
    bus.lock_valid = 1'b1;
    bus.lock_x     = XW'(x);
    bus.lock_y     = YW'(y);
    bus.lock_mask  = m;
    @(posedge CLK); #1;
    bus.lock_valid = 1'b0;
    for (int i = 0; i < 64 && idle < 3; i++) begin
      @(negedge CLK);
      if (busy) bc++; else idle++;
      pulses += int'(clear_pulse);
      lvlups += int'(level_up);
    end
    check_eq("lock_complete", 32'(idle >= 3), 32'd1);
  endtask

  task automatic read_row(input int r, output logic [COLS-1:0] d);
    @(posedge CLK); #1;
    rd_row = YW'(r);
    @(posedge CLK);
    @(negedge CLK);
    d = rd_data;
  endtask

  task automatic check_field_empty(input string tag);
    logic [COLS-1:0] d;
    for (int r = 0; r < int'(TOT); r++) begin
      read_row(r, d);
      check_eq($sformatf("%s_row%0d", tag, r), 32'(d), 32'd0);
    end
  endtask

  task automatic pulse_start();
    @(posedge CLK); #1;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int bc, pulses, lvlups;
    logic [COLS-1:0] d;
    logic [15:0] o_piece, i_horz, i_vert;
    o_piece = PIECE_ROM[1][0];
    i_horz  = PIECE_ROM[0][0];
    i_vert  = PIECE_ROM[0][1];
    bus.q_valid = 1'b0; bus.q_x = '0; bus.q_y = '0; bus.q_mask = '0;
    bus.lock_valid = 1'b0; bus.lock_x = '0; bus.lock_y = '0; bus.lock_mask = '0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    check_eq("rst_q_hit", 32'(bus.q_hit), 0);
    check_eq("rst_q_done", 32'(bus.q_done), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_lock_ready", 32'(bus.lock_ready), 1);
    check_eq("rst_clear_pulse", 32'(clear_pulse), 0);
    check_eq("rst_clear_count", 32'(clear_count), 0);
    check_eq("rst_level", 32'(level), 0);
    check_eq("rst_level_up", 32'(level_up), 0);
    check_eq("rst_line_total", 32'(line_total), 0);
    check_eq("rst_game_over", 32'(game_over), 0);
    check_eq("rst_rd_data", 32'(rd_data), 0);

    // Boundary queries on an empty field.
    query("q_o_origin", 0, 0, o_piece, 1'b0);
    query("q_o_left", -1, 0, o_piece, 1'b1);
    query("q_o_right", int'(COLS) - 1, 0, o_piece, 1'b1);
    query("q_o_below", 0, -1, o_piece, 1'b1);
    query("q_o_right_edge", int'(COLS) - 2, 0, o_piece, 1'b0);
    query("q_o_above_top", 0, int'(TOT) - 1, o_piece, 1'b0);

    // Two horizontal I pieces complete row 0.
    lock_piece(0, 0, i_horz, bc, pulses, lvlups);
    check_eq("i1_busy_cycles", 32'(bc), ROWS + 2);
    check_eq("i1_pulses", 32'(pulses), 0);
    read_row(0, d);
    check_eq("i1_row0", 32'(d), 32'h0F);
    query("q_overlap", 0, 0, o_piece, 1'b1);
    query("q_beside", 4, 0, o_piece, 1'b0);
    lock_piece(4, 0, i_horz, bc, pulses, lvlups);
    check_eq("i2_busy_cycles", 32'(bc), ROWS + 3);
    check_eq("i2_pulses", 32'(pulses), 1);
    check_eq("i2_clear_count", 32'(clear_count), 1);
    check_eq("i2_line_total", 32'(line_total), 1);
    check_eq("i2_level", 32'(level), 0);
    read_row(0, d);
    check_eq("i2_row0", 32'(d), 0);

    pulse_start();
    check_eq("start_line_total", 32'(line_total), 0);

    // Four-row clear with a vertical I.
    lock_piece(0, 0, 16'hFFFF, bc, pulses, lvlups);
    lock_piece(4, 0, 16'h7777, bc, pulses, lvlups);
    read_row(3, d);
    check_eq("fill_row3", 32'(d), 32'h7F);
    lock_piece(7, 0, i_vert, bc, pulses, lvlups);
    check_eq("tetris_busy_cycles", 32'(bc), ROWS + 4 + 2);
    check_eq("tetris_pulses", 32'(pulses), 1);
    check_eq("tetris_clear_count", 32'(clear_count), 4);
    check_eq("tetris_line_total", 32'(line_total), 4);
    check_eq("tetris_level", 32'(level), 1);
    check_eq("tetris_level_up", 32'(lvlups), 1);
    check_field_empty("tetris");

    // start two cycles into SCAN discards the lock.
    @(posedge CLK); #1;
    bus.lock_valid = 1'b1; bus.lock_x = '0; bus.lock_y = '0; bus.lock_mask = i_horz;
    @(posedge CLK); #1;
    bus.lock_valid = 1'b0;
    @(posedge CLK);
    @(posedge CLK); #1;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(negedge CLK);
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_level", 32'(level), 0);
    check_eq("abort_line_total", 32'(line_total), 0);
    check_eq("abort_lock_ready", 32'(bus.lock_ready), 1);
    pulses = int'(clear_pulse);
    repeat (3) begin
      @(negedge CLK);
      pulses += int'(clear_pulse);
    end
    check_eq("abort_pulses", 32'(pulses), 0);
    check_field_empty("abort");

    // Conservative answer while busy.
    @(posedge CLK); #1;
    bus.lock_valid = 1'b1; bus.lock_x = '0; bus.lock_y = '0; bus.lock_mask = i_horz;
    @(posedge CLK); #1;
    bus.lock_valid = 1'b0;
    query("q_while_busy", 4, 5, o_piece, 1'b1);
    for (int i = 0; i < 40 && busy; i++) @(negedge CLK);
    check_eq("busy_fell", 32'(busy), 0);
    query("q_after_busy", 4, 5, o_piece, 1'b0);

    // Stack O pieces at x=3 into the spawn area.
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      lock_piece(3, 2 * k, o_piece, bc, pulses, lvlups);
      check_eq($sformatf("stack%0d_game_over", k), 32'(game_over), 0);
    end
    lock_piece(3, int'(ROWS), o_piece, bc, pulses, lvlups);
    check_eq("top_busy_cycles", 32'(bc), ROWS + 2);
    check_eq("top_game_over", 32'(game_over), 1);
    check_eq("top_lock_ready", 32'(bus.lock_ready), 0);
    @(posedge CLK); #1;
    bus.lock_valid = 1'b1; bus.lock_x = '0; bus.lock_y = '0; bus.lock_mask = o_piece;
    repeat (3) @(negedge CLK);
    check_eq("over_ignored_busy", 32'(busy), 0);
    @(posedge CLK); #1;
    bus.lock_valid = 1'b0;
    read_row(0, d);
    check_eq("over_row0", 32'(d), 32'h18);
    query("q_over_free", 0, 0, o_piece, 1'b0);
    query("q_over_spawn", 3, int'(ROWS), o_piece, 1'b1);
    pulse_start();
    check_eq("restart_game_over", 32'(game_over), 0);
    check_eq("restart_lock_ready", 32'(bus.lock_ready), 1);

    repeat (2) @(negedge CLK);
    check_eq("q_queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
